fpga_config_loader: RTL and testbench

//  Configuration controller for the fabric's logic tiles (33-bit LUT+FF-select word) and 4x4 switch boxes (16-bit crossbar word).

---
 rtl/fpga_cfg_pkg.sv | 34 +++
 rtl/fpga_cfg_crc8.sv | 28 ++
 rtl/fpga_config_loader.sv | 172 +++++++++++++++++
 tb/tb_fpga_config_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the fabric configuration loader.
// FPGA_CFG_CRC_EN adds the CHECK state used for the trailing CRC-8 byte.
package fpga_cfg_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned TILE_BYTES = 5;
    localparam int unsigned SWB_BYTES  = 2;
    localparam int unsigned TILE_W     = 33;
    localparam int unsigned SWB_W      = 16;
    localparam logic [7:0]  CRC_POLY   = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_LOAD_TILE = 3'd2,
        ST_LOAD_SWB  = 3'd3,
`ifdef FPGA_CFG_CRC_EN
        ST_CHECK     = 3'd4,
`endif
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    // One byte of CRC-8, MSB-first, no reflection.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fpga_cfg_crc8.sv
// Byte-serial CRC-8 accumulator over the configuration payload.
// Only instantiated when FPGA_CFG_CRC_EN is defined.
module fpga_cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] r_crc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_crc <= '0;
        end else if (clear) begin
            r_crc <= '0;
        end else if (enable) begin
            r_crc <= crc8_next(r_crc, data_in);
        end
    end

    assign crc_out = r_crc;

endmodule

// File: rtl/fpga_config_loader.sv
// Loads logic-tile and switch-box configuration words from a byte stream.
// FPGA_CFG_CRC_EN: require a trailing CRC-8 byte before enabling the fabric.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned NUM_TILES = 25,
    parameter int unsigned NUM_SWB   = 18,
    parameter logic [7:0]  SYNC_BYTE = fpga_cfg_pkg::SYNC_BYTE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [4:0]        wr_addr,
    output logic [TILE_W-1:0] wr_data,
    output logic              fabric_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] LP_TILE_LAST = 3'(TILE_BYTES - 1);
    localparam logic [2:0] LP_SWB_LAST  = 3'(SWB_BYTES - 1);
    localparam logic [4:0] LP_LAST_TILE = 5'(NUM_TILES - 1);
    localparam logic [4:0] LP_LAST_SWB  = 5'(NUM_SWB - 1);

    state_t            r_state, w_next;
    logic [2:0]        r_byte_cnt;
    logic [4:0]        r_elem_cnt;
    logic [3:0][7:0]   r_word;
    logic              r_wr_en, r_wr_sel;
    logic [4:0]        r_wr_addr;
    logic [TILE_W-1:0] r_wr_data;

    logic              w_xfer, w_loading, w_sync_hit;
    logic              w_last_byte, w_last_elem, w_elem_done;
    logic [TILE_W-1:0] w_wr_data;

    assign w_xfer     = cfg_valid & cfg_ready;
    assign w_loading  = (r_state == ST_LOAD_TILE) || (r_state == ST_LOAD_SWB);
    assign w_sync_hit = w_xfer && (r_state == ST_SYNC) && (cfg_data == SYNC_BYTE);

    always_comb begin
        w_last_byte = 1'b0;
        w_last_elem = 1'b0;
        if (r_state == ST_LOAD_TILE) begin
            w_last_byte = (r_byte_cnt == LP_TILE_LAST);
            w_last_elem = (r_elem_cnt == LP_LAST_TILE);
        end else if (r_state == ST_LOAD_SWB) begin
            w_last_byte = (r_byte_cnt == LP_SWB_LAST);
            w_last_elem = (r_elem_cnt == LP_LAST_SWB);
        end
    end

    assign w_elem_done = w_xfer & w_last_byte;
    // Final byte is taken straight from the bus so the write lands one cycle after it.
    assign w_wr_data = (r_state == ST_LOAD_SWB) ? {17'b0, cfg_data, r_word[0]}
                                                : {cfg_data[0], r_word};

`ifdef FPGA_CFG_CRC_EN
    logic [7:0] w_crc;
    logic       w_crc_ok;

    fpga_cfg_crc8 u_crc (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_sync_hit),
        .enable  (w_xfer & w_loading),
        .data_in (cfg_data),
        .crc_out (w_crc)
    );

    assign w_crc_ok = (cfg_data == w_crc);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) w_next = ST_SYNC;
            ST_SYNC:      if (w_sync_hit) w_next = ST_LOAD_TILE;
            ST_LOAD_TILE: if (w_elem_done && w_last_elem) w_next = ST_LOAD_SWB;
            ST_LOAD_SWB: begin
                if (w_elem_done && w_last_elem) begin
`ifdef FPGA_CFG_CRC_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef FPGA_CFG_CRC_EN
            ST_CHECK:     if (w_xfer) w_next = w_crc_ok ? ST_DONE : ST_ERROR;
`endif
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        fabric_en = 1'b0;
        case (r_state)
            ST_SYNC, ST_LOAD_TILE, ST_LOAD_SWB: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
            end
`ifdef FPGA_CFG_CRC_EN
            ST_CHECK: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                fabric_en = 1'b1;
            end
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_elem_cnt <= '0;
            r_word     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_sel   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_elem_done;
            if (w_elem_done) begin
                r_wr_sel  <= (r_state == ST_LOAD_SWB);
                r_wr_addr <= r_elem_cnt;
                r_wr_data <= w_wr_data;
            end
            if (w_sync_hit) begin
                r_byte_cnt <= '0;
                r_elem_cnt <= '0;
            end else if (w_xfer && w_loading) begin
                r_word[r_byte_cnt[1:0]] <= cfg_data;
                if (w_last_byte) begin
                    r_byte_cnt <= '0;
                    r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + 5'd1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_sel  = r_wr_sel;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed self-checking bench for fpga_config_loader (default and FPGA_CFG_CRC_EN builds).
module tb_fpga_config_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, wr_en, wr_sel, fabric_en, busy, done, error;
    logic [4:0]  wr_addr;
    logic [32:0] wr_data;

    int errors = 0;
    int checks = 0;

    logic [7:0]  pay [161];
    logic [7:0]  crc_good;
    logic        exp_sel  [43];
    logic [4:0]  exp_addr [43];
    logic [32:0] exp_data [43];

    int          n_wr = 0;
    logic        log_sel  [128];
    logic [4:0]  log_addr [128];
    logic [32:0] log_data [128];

    fpga_config_loader #(.NUM_TILES(25), .NUM_SWB(18), .SYNC_BYTE(8'hA5)) dut (
        .clock(clock), .reset(reset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .fabric_en(fabric_en), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            if (n_wr < 128) begin
                log_sel[n_wr]  = wr_sel;
                log_addr[n_wr] = wr_addr;
                log_data[n_wr] = wr_data;
            end
            n_wr = n_wr + 1;
        end
    end

    task automatic send(input logic [7:0] b);
        cfg_data  = b;
        cfg_valid = 1'b1;
        @(posedge clock); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        cfg_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            cfg_data = 8'($urandom);
            @(posedge clock); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #13;
        if ({cfg_ready, wr_en, wr_sel, wr_addr, wr_data, fabric_en, busy, done, error} !== 45'd0) begin
            $display("FAIL reset_outputs: got %h want 0",
                     {cfg_ready, wr_en, wr_sel, wr_addr, wr_data, fabric_en, busy, done, error});
            errors++;
        end
        checks++;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            $display("FAIL idle_no_ready: busy=%b ready=%b want 0 0", busy, cfg_ready);
            errors++;
        end
        checks++;
    endtask

    task automatic test_sync();
        n_wr = 0;
        pulse_start();
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            $display("FAIL sync_entry: busy=%b ready=%b want 1 1", busy, cfg_ready);
            errors++;
        end
        checks++;
        send(8'h00);
        send(8'h13);
        send(8'hA5);
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || n_wr != 0 || wr_en !== 1'b0) begin
            $display("FAIL sync_discard: busy=%b ready=%b writes=%0d wr_en=%b want 1 1 0 0",
                     busy, cfg_ready, n_wr, wr_en);
            errors++;
        end
        checks++;
    endtask

    task automatic test_tile0();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        if (wr_en !== 1'b0) begin
            $display("FAIL tile0_early: wr_en=%b want 0", wr_en);
            errors++;
        end
        checks++;
        send(8'hFF);
        if (wr_en !== 1'b1 || wr_sel !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 33'h1_0403_0201) begin
            $display("FAIL tile0_write: en=%b sel=%b addr=%0d data=%h want 1 0 0 104030201",
                     wr_en, wr_sel, wr_addr, wr_data);
            errors++;
        end
        checks++;
        @(posedge clock); #1;
        if (wr_en !== 1'b0) begin
            $display("FAIL tile0_pulse_width: wr_en=%b want 0", wr_en);
            errors++;
        end
        checks++;
    endtask

    task automatic test_full_stream();
        do_reset();
        n_wr = 0;
        pulse_start();
        send(8'hA5);
        for (int i = 0; i < 161; i++) send(pay[i]);
`ifdef FPGA_CFG_CRC_EN
        if (wr_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL last_write_check: en=%b busy=%b done=%b want 1 1 0", wr_en, busy, done);
            errors++;
        end
        checks++;
        send(crc_good);
`else
        if (wr_en !== 1'b1 || done !== 1'b1 || fabric_en !== 1'b1) begin
            $display("FAIL last_write_done: en=%b done=%b fab=%b want 1 1 1", wr_en, done, fabric_en);
            errors++;
        end
        checks++;
`endif
        gap(2);
        if (done !== 1'b1 || fabric_en !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0 || error !== 1'b0) begin
            $display("FAIL full_done: done=%b fab=%b busy=%b ready=%b err=%b want 1 1 0 0 0",
                     done, fabric_en, busy, cfg_ready, error);
            errors++;
        end
        checks++;
        if (n_wr != 43) begin
            $display("FAIL full_count: got %0d want 43", n_wr);
            errors++;
        end
        checks++;
        for (int k = 0; k < 43; k++) begin
            if (log_sel[k] !== exp_sel[k] || log_addr[k] !== exp_addr[k] || log_data[k] !== exp_data[k]) begin
                $display("FAIL full_write%0d: sel=%b addr=%0d data=%h want %b %0d %h", k,
                         log_sel[k], log_addr[k], log_data[k], exp_sel[k], exp_addr[k], exp_data[k]);
                errors++;
            end
            checks++;
        end
        if (log_sel[42] !== 1'b1 || log_addr[42] !== 5'd17) begin
            $display("FAIL full_last: sel=%b addr=%0d want 1 17", log_sel[42], log_addr[42]);
            errors++;
        end
        checks++;
    endtask

    task automatic test_throttled();
        n_wr = 0;
        pulse_start();
        if (fabric_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL restart_from_done: fab=%b done=%b busy=%b want 0 0 1", fabric_en, done, busy);
            errors++;
        end
        checks++;
        send(8'hA5);
        for (int i = 0; i < 161; i++) begin
            if (i == 7) start = 1'b1;
            send(pay[i]);
            start = 1'b0;
            gap($urandom_range(0, 2));
        end
`ifdef FPGA_CFG_CRC_EN
        send(crc_good);
`endif
        gap(2);
        if (done !== 1'b1 || fabric_en !== 1'b1 || n_wr != 43) begin
            $display("FAIL throttled_done: done=%b fab=%b writes=%0d want 1 1 43", done, fabric_en, n_wr);
            errors++;
        end
        checks++;
        for (int k = 0; k < 43; k++) begin
            if (log_sel[k] !== exp_sel[k] || log_addr[k] !== exp_addr[k] || log_data[k] !== exp_data[k]) begin
                $display("FAIL throttled_write%0d: sel=%b addr=%0d data=%h want %b %0d %h", k,
                         log_sel[k], log_addr[k], log_data[k], exp_sel[k], exp_addr[k], exp_data[k]);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        n_wr = 0;
        pulse_start();
        send(8'hA5);
        for (int i = 0; i < 60; i++) send(pay[i]);
        if (wr_en !== 1'b1 || wr_addr !== 5'd11) begin
            $display("FAIL midload_tile11: en=%b addr=%0d want 1 11", wr_en, wr_addr);
            errors++;
        end
        checks++;
        reset = 1'b1;
        #1;
        if ({cfg_ready, wr_en, wr_sel, wr_addr, wr_data, fabric_en, busy, done, error} !== 45'd0) begin
            $display("FAIL midload_reset_outputs: got %h want 0",
                     {cfg_ready, wr_en, wr_sel, wr_addr, wr_data, fabric_en, busy, done, error});
            errors++;
        end
        checks++;
        @(posedge clock); #1;
        reset = 1'b0;
        gap(3);
        if (n_wr != 11 || fabric_en !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL midload_quiet: writes=%0d fab=%b busy=%b want 11 0 0", n_wr, fabric_en, busy);
            errors++;
        end
        checks++;
        pulse_start();
        send(8'hA5);
        for (int i = 0; i < 161; i++) send(pay[i]);
`ifdef FPGA_CFG_CRC_EN
        send(crc_good);
`endif
        gap(2);
        if (done !== 1'b1 || fabric_en !== 1'b1 || n_wr != 54) begin
            $display("FAIL midload_reload: done=%b fab=%b writes=%0d want 1 1 54", done, fabric_en, n_wr);
            errors++;
        end
        checks++;
        for (int k = 0; k < 43; k++) begin
            if (log_sel[11+k] !== exp_sel[k] || log_addr[11+k] !== exp_addr[k] || log_data[11+k] !== exp_data[k]) begin
                $display("FAIL reload_write%0d: sel=%b addr=%0d data=%h want %b %0d %h", k,
                         log_sel[11+k], log_addr[11+k], log_data[11+k], exp_sel[k], exp_addr[k], exp_data[k]);
                errors++;
            end
            checks++;
        end
    endtask

`ifdef FPGA_CFG_CRC_EN
    task automatic test_crc_error();
        do_reset();
        n_wr = 0;
        pulse_start();
        send(8'hA5);
        for (int i = 0; i < 161; i++) send(pay[i]);
        send(crc_good ^ 8'h01);
        gap(1);
        if (error !== 1'b1 || fabric_en !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0 || n_wr != 43) begin
            $display("FAIL crc_bad: err=%b fab=%b done=%b ready=%b writes=%0d want 1 0 0 0 43",
                     error, fabric_en, done, cfg_ready, n_wr);
            errors++;
        end
        checks++;
        pulse_start();
        if (error !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL crc_restart: err=%b busy=%b want 0 1", error, busy);
            errors++;
        end
        checks++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        logic       fb;
        for (int i = 0; i < 161; i++) pay[i] = 8'((i * 37 + 11) % 256);
        c = 8'h00;
        for (int i = 0; i < 161; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ pay[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        crc_good = c;
        for (int t = 0; t < 25; t++) begin
            exp_sel[t]  = 1'b0;
            exp_addr[t] = 5'(t);
            exp_data[t] = {pay[5*t+4][0], pay[5*t+3], pay[5*t+2], pay[5*t+1], pay[5*t]};
        end
        for (int s = 0; s < 18; s++) begin
            exp_sel[25+s]  = 1'b1;
            exp_addr[25+s] = 5'(s);
            exp_data[25+s] = {17'd0, pay[125+2*s+1], pay[125+2*s]};
        end

        test_reset();
        test_sync();
        test_tile0();
        test_full_stream();
        test_throttled();
        test_reset_mid_load();
`ifdef FPGA_CFG_CRC_EN
        test_crc_error();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
